// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared defaults, constants and helpers for the register file
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// regfile_mp_if : read/write/issue bus between ID, EX/WB and the register file
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);

  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      rbusy_o;
  logic [NWR-1:0]      wen_i;
  logic [NWR*AW-1:0]   waddr_i;
  logic [NWR*XLEN-1:0] wdata_i;
  logic                issue_en_i;
  logic [AW-1:0]       issue_rd_i;
  logic                flush_i;

  modport master (
    output raddr_i, wen_i, waddr_i, wdata_i, issue_en_i, issue_rd_i, flush_i,
    input  rdata_o, rbusy_o
  );

  modport slave (
    input  raddr_i, wen_i, waddr_i, wdata_i, issue_en_i, issue_rd_i, flush_i,
    output rdata_o, rbusy_o
  );

endinterface

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// ============================================================================
// rf_scoreboard : per-register busy bits for outstanding writers (RAW detect)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  parameter int NRD   = 2,
  parameter int AW    = clog2(NREGS)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [NWR-1:0]    i_wen,
  input  wire logic [NWR*AW-1:0] i_waddr,
  input  wire logic              i_issue_en,
  input  wire logic [AW-1:0]     i_issue_rd,
  input  wire logic              i_flush,
  input  wire logic [NRD*AW-1:0] i_raddr,
  output logic      [NRD-1:0]    o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic [NREGS-1:0] w_wr_hit;

  always_comb begin
    w_wr_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (i_wen[j] && (i_waddr[j*AW +: AW] == AW'(r))) w_wr_hit[r] = 1'b1;
      end
    end
  end

  // A new issue beats a retiring write to the same register: the issuer is the newer producer.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (i_issue_en && (i_issue_rd == AW'(r))) w_busy_nxt[r] = 1'b1;
        else if (w_wr_hit[r])                     w_busy_nxt[r] = 1'b0;
      end
    end
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      o_busy[k] = rst & r_busy[i_raddr[k*AW +: AW]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// regfile_mp : multi-port integer register file with forwarding and scoreboard
// Revision   : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input wire logic    clk,
  input wire logic    rst,
  regfile_mp_if.slave rf
);

  localparam int AW = clog2(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NRD-1:0]  w_sb_busy;
  logic [NRD-1:0]  w_fwd;
  logic [AW-1:0]   w_ra [NRD];
  logic [XLEN-1:0] w_rd [NRD];

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .NRD   (NRD),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_wen      (rf.wen_i),
    .i_waddr    (rf.waddr_i),
    .i_issue_en (rf.issue_en_i),
    .i_issue_rd (rf.issue_rd_i),
    .i_flush    (rf.flush_i),
    .i_raddr    (rf.raddr_i),
    .o_busy     (w_sb_busy)
  );

  // Later ports are applied last, so the highest-index writer to an address wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) r_regs[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (rf.wen_i[j] && (rf.waddr_i[j*AW +: AW] != AW'(REG_ZERO)))
          r_regs[rf.waddr_i[j*AW +: AW]] <= rf.wdata_i[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    w_fwd      = '0;
    rf.rdata_o = '0;
    rf.rbusy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      w_ra[k] = rf.raddr_i[k*AW +: AW];
      w_rd[k] = r_regs[w_ra[k]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (rf.wen_i[j] && (rf.waddr_i[j*AW +: AW] == w_ra[k])) begin
            w_fwd[k] = 1'b1;
            w_rd[k]  = rf.wdata_i[j*XLEN +: XLEN];
          end
        end
      end
      if (!rst || (w_ra[k] == AW'(REG_ZERO))) begin
        w_fwd[k] = 1'b0;
        w_rd[k]  = '0;
      end
      rf.rdata_o[k*XLEN +: XLEN] = w_rd[k];
      // Forwarded data resolves the hazard, so a matching write hides the busy bit.
      rf.rbusy_o[k] = w_sb_busy[k] & ~w_fwd[k];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// tb_regfile_mp : directed vectors for regfile_mp, BYPASS=1 and BYPASS=0 copies
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) ifb ();
  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) ifn ();

  assign ifn.raddr_i    = ifb.raddr_i;
  assign ifn.wen_i      = ifb.wen_i;
  assign ifn.waddr_i    = ifb.waddr_i;
  assign ifn.wdata_i    = ifb.wdata_i;
  assign ifn.issue_en_i = ifb.issue_en_i;
  assign ifn.issue_rd_i = ifb.issue_rd_i;
  assign ifn.flush_i    = ifb.flush_i;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .rf  (ifb)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .rf  (ifn)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iss;
    logic [4:0]  ird;
    logic        fl;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_bz;
    logic [31:0] e_nrd0;
    logic [1:0]  e_nbz;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(
    input logic rs, input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1, input logic iss, input logic [4:0] ird,
    input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] ebz,
    input logic [31:0] en0, input logic [1:0] enbz);
    vec_t v;
    v.rst = rs;  v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iss = iss; v.ird = ird; v.fl = fl;   v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_bz = ebz; v.e_nrd0 = en0; v.e_nbz = enbz;
    return v;
  endfunction

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                      = v.rst;
    ifb.wen_i                = v.wen;
    ifb.waddr_i              = {v.wa1, v.wa0};
    ifb.wdata_i              = {v.wd1, v.wd0};
    ifb.issue_en_i           = v.iss;
    ifb.issue_rd_i           = v.ird;
    ifb.flush_i              = v.fl;
    ifb.raddr_i              = {v.ra1, v.ra0};
  endtask

  initial begin
    // rst wen wa0 wd0 wa1 wd1 iss ird fl ra0 ra1 | rd0 rd1 bz | n_rd0 n_bz
    vecs.push_back(mk(0, 2'b00,  0, 0,            0, 0,        0, 0, 0, 31, 0,  0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b01, 31, 32'hDEADBEEF, 0, 0,        0, 0, 0, 31, 5,  32'hDEADBEEF, 0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 31, 0,  32'hDEADBEEF, 0,     2'b00, 32'hDEADBEEF, 2'b00));
    vecs.push_back(mk(0, 2'b01, 31, 32'h1,        0, 0,        1, 5, 0, 31, 31, 0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(0, 2'b00,  0, 0,            0, 0,        0, 0, 0, 31, 0,  0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 31, 5,  0,            0,     2'b00, 0,            2'b00));
    // x0 protection
    vecs.push_back(mk(1, 2'b11,  0, 32'h1234,     0, 32'h1234, 1, 0, 0, 0,  0,  0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 0,  0,  0,            0,     2'b00, 0,            2'b00));
    // dual-port write to x5: higher port wins for forwarding and storage
    vecs.push_back(mk(1, 2'b11,  5, 32'hA,        5, 32'hB,    0, 0, 0, 5,  5,  32'hB,        32'hB, 2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 5,  5,  32'hB,        32'hB, 2'b00, 32'hB,        2'b00));
    vecs.push_back(mk(1, 2'b01,  6, 32'hC,        0, 0,        0, 0, 0, 6,  5,  32'hC,        32'hB, 2'b00, 0,            2'b00));
    // scoreboard lifecycle on x7
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        1, 7, 0, 7,  6,  0,            32'hC, 2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 7,  7,  0,            0,     2'b11, 0,            2'b11));
    vecs.push_back(mk(1, 2'b01,  7, 32'h55,       0, 0,        0, 0, 0, 7,  6,  32'h55,       32'hC, 2'b00, 0,            2'b01));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 7,  7,  32'h55,       32'h55,2'b00, 32'h55,       2'b00));
    // issue and writeback to x9 in the same cycle
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        1, 9, 0, 9,  0,  0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b10,  0, 0,            9, 32'h99,   1, 9, 0, 9,  9,  32'h99,       32'h99,2'b00, 0,            2'b11));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 9,  9,  32'h99,       32'h99,2'b11, 32'h99,       2'b11));
    vecs.push_back(mk(1, 2'b01,  9, 32'h77,       0, 0,        0, 0, 0, 9,  3,  32'h77,       0,     2'b00, 32'h99,       2'b01));
    // busy x3, x4, x6 then flush with issue x8 and a write to x4
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        1, 3, 0, 3,  4,  0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        1, 4, 0, 3,  4,  0,            0,     2'b01, 0,            2'b01));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        1, 6, 0, 3,  4,  0,            0,     2'b11, 0,            2'b11));
    vecs.push_back(mk(1, 2'b01,  4, 32'h44,       0, 0,        1, 8, 1, 6,  3,  32'hC,        0,     2'b11, 32'hC,        2'b11));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 3,  4,  0,            32'h44,2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 6,  8,  32'hC,        0,     2'b00, 32'hC,        2'b00));
    // reset discards pending busy state
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        1,10, 0, 10, 9,  0,            32'h77,2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 10, 9,  0,            32'h77,2'b01, 0,            2'b01));
    vecs.push_back(mk(0, 2'b00,  0, 0,            0, 0,        0, 0, 0, 10, 9,  0,            0,     2'b00, 0,            2'b00));
    vecs.push_back(mk(1, 2'b00,  0, 0,            0, 0,        0, 0, 0, 10, 9,  0,            0,     2'b00, 0,            2'b00));

    drive(vecs[0]);
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      chk(i, "byp_rdata0", ifb.rdata_o[31:0],  vecs[i].e_rd0);
      chk(i, "byp_rdata1", ifb.rdata_o[63:32], vecs[i].e_rd1);
      chk(i, "byp_rbusy",  {30'd0, ifb.rbusy_o}, {30'd0, vecs[i].e_bz});
      chk(i, "nob_rdata0", ifn.rdata_o[31:0],  vecs[i].e_nrd0);
      chk(i, "nob_rbusy",  {30'd0, ifn.rbusy_o}, {30'd0, vecs[i].e_nbz});
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
